// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_wport_arbiter_pkg;

  localparam int unsigned RF_ADDR_W    = 5;
  localparam int unsigned RF_ENTRIES   = 32;
  localparam int unsigned RF_FWD_PORTS = 3;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  // True on the final address of the clear sweep.
  function automatic logic rf_is_last_entry(input rf_addr_t addr);
    return addr == RF_ADDR_W'(RF_ENTRIES - 1);
  endfunction

endpackage

// File: rtl/rf_wfifo.sv
// Two-in/one-out in-order write FIFO. Entries are exposed oldest-first so the
// caller can read the head at index 0 and search the whole occupied range.
module rf_wfifo
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push0_i,
  input  rf_addr_t               addr0_i,
  input  logic [WIDTH-1:0]       data0_i,
  input  logic                   push1_i,
  input  rf_addr_t               addr1_i,
  input  logic [WIDTH-1:0]       data1_i,
  input  logic                   pop_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [DEPTH-1:0]       ent_valid_o,
  output rf_addr_t               ent_addr_o [DEPTH],
  output logic [WIDTH-1:0]       ent_data_o [DEPTH]
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rf_addr_t         addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_idx1;

  // Lane 1 lands behind lane 0 when both push in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
    wr_idx1  = push0_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push0_i) begin
        addr_q[wr_ptr_q] <= addr0_i;
        data_q[wr_ptr_q] <= data0_i;
      end
      if (push1_i) begin
        addr_q[wr_idx1] <= addr1_i;
        data_q[wr_idx1] <= data1_i;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      ent_valid_o[k] = CNT_W'(k) < count_q;
      ent_addr_o[k]  = addr_q[rd_ptr_q + PTR_W'(k)];
      ent_data_o[k]  = data_q[rd_ptr_q + PTR_W'(k)];
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port controller: clears all entries after reset, then
// merges two writeback lanes into the RAM write port. RF_WPORT_FWD_EN adds lookups.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb0_valid_i,
  output logic             wb0_ready_o,
  input  rf_addr_t         wb0_addr_i,
  input  logic [WIDTH-1:0] wb0_data_i,
  input  logic             wb1_valid_i,
  output logic             wb1_ready_o,
  input  rf_addr_t         wb1_addr_i,
  input  logic [WIDTH-1:0] wb1_data_i,
  output rf_addr_t         ram_addrw_o,
  output logic [WIDTH-1:0] ram_din_o,
  output logic             ram_wea_o,
  output logic             init_done_o,
`ifdef RF_WPORT_FWD_EN
  input  rf_addr_t         fwd_addr_i [RF_FWD_PORTS],
  output logic             fwd_hit_o  [RF_FWD_PORTS],
  output logic [WIDTH-1:0] fwd_data_o [RF_FWD_PORTS],
`endif
  output logic             pending_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  rf_state_e        state_q, state_d;
  rf_addr_t         cnt_q, cnt_d;
  logic             init_done_q;
  logic             push0, push1, pop;
  logic [CNT_W-1:0] fifo_count;
  logic [FIFO_DEPTH-1:0] ent_valid;
  rf_addr_t         ent_addr [FIFO_DEPTH];
  logic [WIDTH-1:0] ent_data [FIFO_DEPTH];

  rf_wfifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push0_i     (push0),
    .addr0_i     (wb0_addr_i),
    .data0_i     (wb0_data_i),
    .push1_i     (push1),
    .addr1_i     (wb1_addr_i),
    .data1_i     (wb1_data_i),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .ent_valid_o (ent_valid),
    .ent_addr_o  (ent_addr),
    .ent_data_o  (ent_data)
  );

  assign pending_o = |ent_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RF_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == RF_RUN);
    end
  end

  // Sweep in INIT; in RUN readiness comes only from start-of-cycle occupancy.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_wea_o   = 1'b0;
    ram_addrw_o = '0;
    ram_din_o   = '0;
    wb0_ready_o = 1'b0;
    wb1_ready_o = 1'b0;
    pop         = 1'b0;
    case (state_q)
      RF_INIT: begin
        ram_wea_o   = 1'b1;
        ram_addrw_o = cnt_q;
        cnt_d       = cnt_q + RF_ADDR_W'(1);
        if (rf_is_last_entry(cnt_q)) begin
          state_d = RF_RUN;
        end
      end
      RF_RUN: begin
        wb0_ready_o = fifo_count < CNT_W'(FIFO_DEPTH);
        wb1_ready_o = fifo_count < CNT_W'(FIFO_DEPTH - 1);
        pop         = pending_o;
        if (pending_o) begin
          ram_wea_o   = 1'b1;
          ram_addrw_o = ent_addr[0];
          ram_din_o   = ent_data[0];
        end
      end
      default: begin
        state_d = RF_INIT;
      end
    endcase
  end

  // r0 is hardwired zero, so writes to it are accepted and dropped.
  always_comb begin
    push0 = wb0_valid_i && wb0_ready_o && (wb0_addr_i != '0);
    push1 = wb1_valid_i && wb1_ready_o && (wb1_addr_i != '0);
  end

  assign init_done_o = init_done_q;

`ifdef RF_WPORT_FWD_EN
  // Later (younger) entries override earlier matches.
  always_comb begin
    for (int p = 0; p < int'(RF_FWD_PORTS); p++) begin
      fwd_hit_o[p]  = 1'b0;
      fwd_data_o[p] = '0;
      for (int k = 0; k < int'(FIFO_DEPTH); k++) begin
        if ((state_q == RF_RUN) && ent_valid[k] && (fwd_addr_i[p] != '0) &&
            (ent_addr[k] == fwd_addr_i[p])) begin
          fwd_hit_o[p]  = 1'b1;
          fwd_data_o[p] = ent_data[k];
        end
      end
    end
  end
`endif

endmodule
